// File: rtl/frame_line_finder.sv
// Scans a horizontal band of a frame RAM, counts dark pixels per zone, picks a steering direction.
// Latency: result pulse 3 cycles after the last band address (N+3 cycles after the start edge).
// Backpressure: none; start edges seen while busy are dropped, capture is held off while busy.
module frame_line_finder #(
  parameter int          IMG_W      = 160,
  parameter int          IMG_H      = 120,
  parameter int          ROW_START  = 100,
  parameter int          ROW_END    = 119,
  parameter logic [7:0]  THRESHOLD  = 8'd80,
  parameter int          MIN_PIXELS = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Start,
  output logic [14:0] o_RAM_Address,
  input  logic [7:0]  i_RAM_Data,
  output logic        o_Camera_Read_Enable,
  output logic        o_Busy,
  output logic [14:0] o_Left_Count,
  output logic [14:0] o_Center_Count,
  output logic [14:0] o_Right_Count,
  output logic [1:0]  o_Direction,
  output logic        o_Result_Valid
);

  // Band never extends past the bottom of the frame.
  localparam int LAST_ROW = (ROW_END < IMG_H) ? ROW_END : IMG_H - 1;
  localparam int BASE     = ROW_START * IMG_W;
  localparam int N_PIX    = (LAST_ROW - ROW_START + 1) * IMG_W;
  localparam int XW       = $clog2(IMG_W);

  localparam logic [14:0]   BASE_ADDR = 15'(BASE);
  localparam logic [14:0]   LAST_ADDR = 15'(BASE + N_PIX - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_W - 1);
  localparam logic [XW-1:0] ZONE_1    = XW'(IMG_W / 3);
  localparam logic [XW-1:0] ZONE_2    = XW'((2 * IMG_W) / 3);
  localparam logic [14:0]   MIN_CNT   = 15'(MIN_PIXELS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DECIDE = 2'd3;

  localparam logic [1:0] DIR_NONE   = 2'b00;
  localparam logic [1:0] DIR_LEFT   = 2'b01;
  localparam logic [1:0] DIR_CENTER = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;

  logic [1:0]    state;
  logic          start_prev;
  logic          start_edge;
  logic [XW-1:0] x;
  logic [XW-1:0] x_d;
  logic          pix_vld;
  logic [14:0]   acc_left;
  logic [14:0]   acc_center;
  logic [14:0]   acc_right;
  logic [1:0]    dir_next;

  assign start_edge           = i_Start & ~start_prev;
  assign o_Busy               = (state != S_IDLE);
  assign o_Camera_Read_Enable = ~o_Busy;

  // Previous i_Start level for rising-edge detection.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) start_prev <= 1'b0;
    else          start_prev <= i_Start;
  end

  // Scan sequencer: walks the band addresses and the column counter alongside.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state         <= S_IDLE;
      o_RAM_Address <= 15'd0;
      x             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state         <= S_READ;
            o_RAM_Address <= BASE_ADDR;
            x             <= '0;
          end
        end
        S_READ: begin
          if (o_RAM_Address == LAST_ADDR) begin
            state <= S_DRAIN;
          end else begin
            o_RAM_Address <= o_RAM_Address + 15'd1;
            x             <= (x == X_LAST) ? '0 : x + 1'b1;
          end
        end
        S_DRAIN:  state <= S_DECIDE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // RAM data arrives one cycle after its address; delay the qualifier and column to match.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pix_vld <= 1'b0;
      x_d     <= '0;
    end else begin
      pix_vld <= (state == S_READ);
      x_d     <= x;
    end
  end

  // Per-zone dark pixel accumulation, cleared when a scan is accepted.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      acc_left   <= 15'd0;
      acc_center <= 15'd0;
      acc_right  <= 15'd0;
    end else if (state == S_IDLE && start_edge) begin
      acc_left   <= 15'd0;
      acc_center <= 15'd0;
      acc_right  <= 15'd0;
    end else if (pix_vld && (i_RAM_Data < THRESHOLD)) begin
      if (x_d < ZONE_1)      acc_left   <= acc_left + 15'd1;
      else if (x_d < ZONE_2) acc_center <= acc_center + 15'd1;
      else                   acc_right  <= acc_right + 15'd1;
    end
  end

  // Winner selection: center wins ties with either side, left wins ties with right.
  always_comb begin
    dir_next = DIR_NONE;
    if (acc_center >= acc_left && acc_center >= acc_right) begin
      if (acc_center >= MIN_CNT) dir_next = DIR_CENTER;
    end else if (acc_left >= acc_right) begin
      if (acc_left >= MIN_CNT) dir_next = DIR_LEFT;
    end else begin
      if (acc_right >= MIN_CNT) dir_next = DIR_RIGHT;
    end
  end

  // Publish results once per completed scan; they hold until the next one.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      o_Left_Count   <= 15'd0;
      o_Center_Count <= 15'd0;
      o_Right_Count  <= 15'd0;
      o_Direction    <= DIR_NONE;
      o_Result_Valid <= 1'b0;
    end else begin
      o_Result_Valid <= 1'b0;
      if (state == S_DECIDE) begin
        o_Left_Count   <= acc_left;
        o_Center_Count <= acc_center;
        o_Right_Count  <= acc_right;
        o_Direction    <= dir_next;
        o_Result_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_line_finder.sv
// Bench for frame_line_finder: directed band patterns plus random frames against a zone-count model.
// Checks addresses, latency, pulse count, counts, direction, reset and busy behaviour.
module tb_frame_line_finder;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int RS    = 100;
  localparam int RE    = 119;
  localparam int TH    = 80;
  localparam int MINP  = 16;
  localparam int BASE  = RS * IMG_W;
  localparam int N     = (RE - RS + 1) * IMG_W;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Start = 1'b0;
  logic [14:0] ram_addr;
  logic [7:0]  ram_data;
  logic        cam_re;
  logic        busy;
  logic [14:0] left_cnt, center_cnt, right_cnt;
  logic [1:0]  direction;
  logic        res_vld;

  logic [7:0] mem [0:IMG_W*IMG_H-1];

  int total = 0;
  int bad   = 0;

  always #5 i_Clk = ~i_Clk;

  // Synchronous frame RAM: data for the address of one cycle shows up the next.
  always @(posedge i_Clk) ram_data <= mem[ram_addr];

  frame_line_finder dut (
    .i_Clk               (i_Clk),
    .i_Rst_n             (i_Rst_n),
    .i_Start             (i_Start),
    .o_RAM_Address       (ram_addr),
    .i_RAM_Data          (ram_data),
    .o_Camera_Read_Enable(cam_re),
    .o_Busy              (busy),
    .o_Left_Count        (left_cnt),
    .o_Center_Count      (center_cnt),
    .o_Right_Count       (right_cnt),
    .o_Direction         (direction),
    .o_Result_Valid      (res_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < IMG_W*IMG_H; i++) mem[i] = v;
  endtask

  task automatic dark_cols(input int c0, input int c1);
    for (int r = RS; r <= RE; r++)
      for (int c = c0; c <= c1; c++) mem[r*IMG_W + c] = 8'h10;
  endtask

  // Reference: count band pixels below threshold by zone, then apply the priority rule.
  task automatic model(output int l, output int c, output int r, output logic [1:0] d);
    int mx;
    l = 0; c = 0; r = 0;
    for (int row = RS; row <= RE; row++)
      for (int col = 0; col < IMG_W; col++)
        if (mem[row*IMG_W + col] < TH) begin
          if (col < IMG_W/3)          l++;
          else if (col < 2*IMG_W/3)   c++;
          else                        r++;
        end
    mx = (l > c) ? l : c;
    if (r > mx) mx = r;
    if (mx < MINP)      d = 2'b00;
    else if (c == mx)   d = 2'b10;
    else if (l == mx)   d = 2'b01;
    else                d = 2'b11;
  endtask

  task automatic run_frame(input string name, input bit busy_restart);
    int l, c, r;
    logic [1:0] d;
    int vk = -1;
    int pulses = 0;
    bit addr_ok = 1'b1;
    bit scan_ok = 1'b1;
    model(l, c, r, d);
    @(negedge i_Clk) i_Start = 1'b1;
    @(posedge i_Clk);
    for (int k = 1; k <= N + 12; k++) begin
      @(negedge i_Clk);
      if (k == 2) i_Start = 1'b0;
      if (busy_restart && k == 500) i_Start = 1'b1;
      if (busy_restart && k == 510) i_Start = 1'b0;
      if (k <= N) begin
        if (ram_addr !== 15'(BASE + k - 1)) addr_ok = 1'b0;
        if (cam_re !== 1'b0 || busy !== 1'b1) scan_ok = 1'b0;
      end
      if (res_vld === 1'b1) begin
        pulses++;
        if (vk < 0) vk = k;
      end
    end
    chk({name, ":addr_seq"}, 32'(addr_ok), 32'd1);
    chk({name, ":busy_scan"}, 32'(scan_ok), 32'd1);
    chk({name, ":latency"}, vk, N + 3);
    chk({name, ":pulses"}, pulses, 1);
    chk({name, ":left"}, 32'(left_cnt), l);
    chk({name, ":center"}, 32'(center_cnt), c);
    chk({name, ":right"}, 32'(right_cnt), r);
    chk({name, ":dir"}, 32'(direction), 32'(d));
    chk({name, ":idle_cam"}, {busy, cam_re}, 32'b01);
    chk({name, ":addr_hold"}, 32'(ram_addr), BASE + N - 1);
  endtask

  task automatic reset_mid_scan();
    int pulses = 0;
    @(negedge i_Clk) i_Start = 1'b1;
    @(posedge i_Clk);
    for (int k = 1; k < 1000; k++) begin
      @(negedge i_Clk);
      if (k == 2) i_Start = 1'b0;
      if (res_vld === 1'b1) pulses++;
    end
    i_Rst_n = 1'b0;
    @(posedge i_Clk);
    @(posedge i_Clk);
    @(negedge i_Clk);
    chk("rst_mid:pulses", pulses, 0);
    chk("rst_mid:busy", 32'(busy), 0);
    chk("rst_mid:cam", 32'(cam_re), 1);
    chk("rst_mid:vld", 32'(res_vld), 0);
    chk("rst_mid:counts", 32'(left_cnt) + 32'(center_cnt) + 32'(right_cnt), 0);
    chk("rst_mid:dir", 32'(direction), 0);
    chk("rst_mid:addr", 32'(ram_addr), 0);
    i_Rst_n = 1'b1;
    repeat (3) @(negedge i_Clk);
    chk("rst_mid:no_spurious", 32'(busy), 0);
  endtask

  initial begin
    set_all(8'hFF);
    i_Rst_n = 1'b0;
    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    chk("reset:addr", 32'(ram_addr), 0);
    chk("reset:busy", 32'(busy), 0);
    chk("reset:cam", 32'(cam_re), 1);
    chk("reset:vld", 32'(res_vld), 0);
    chk("reset:dir", 32'(direction), 0);
    chk("reset:counts", 32'(left_cnt) + 32'(center_cnt) + 32'(right_cnt), 0);
    i_Rst_n = 1'b1;
    repeat (2) @(negedge i_Clk);

    set_all(8'hFF);                        run_frame("white", 1'b0);
    set_all(8'hFF); dark_cols(0, 10);      run_frame("left220", 1'b0);
    set_all(8'hFF); dark_cols(70, 89);     run_frame("center400", 1'b0);
    set_all(8'hFF); dark_cols(120, 159);   run_frame("right800", 1'b0);
    set_all(8'hFF); dark_cols(0, 9); dark_cols(150, 159);
    run_frame("tie_lr", 1'b0);
    set_all(8'hFF); dark_cols(0, 9); dark_cols(60, 69);
    run_frame("tie_lc", 1'b0);
    set_all(8'hFF);
    for (int c = 0; c < 15; c++) mem[RS*IMG_W + c] = 8'h00;
    run_frame("below_min", 1'b0);
    set_all(8'hFF);
    for (int c = 140; c < 156; c++) mem[RE*IMG_W + c] = 8'd79;
    run_frame("at_min", 1'b0);
    set_all(8'hFF); dark_cols(70, 89);     run_frame("busy_restart", 1'b1);

    set_all(8'hFF); dark_cols(120, 159);
    reset_mid_scan();
    set_all(8'hFF); dark_cols(30, 40);     run_frame("after_reset", 1'b0);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < IMG_W*IMG_H; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 80)) : 8'($urandom_range(80, 255));
      run_frame($sformatf("rand%0d", t), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
